// File: rtl/usr_seq.sv
// usr_seq - command sequencer for a 4-bit universal shift register stage.
//
// Takes one operation per valid/ready handshake and drives the register's
// sel/shift_en/data_in for the commanded number of cycles. Between
// operations the register output is fed back as a parallel load so the
// register holds its contents. Completion is flagged with a one-cycle done.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   clr        synchronous active-high reset (shared with the register)
//   cmd_valid  command presented
//   cmd_ready  sequencer can accept a command (IDLE and not in reset)
//   cmd_op     00 LOAD, 01 SHR_ZERO, 10 SHR_IN, 11 SHL_IN
//   cmd_data   load value / serial-fill source, latched at accept
//   cmd_count  number of shift cycles (ignored for LOAD)
//   usr_q      current register output, used for hold
//   sel        register mode select
//   shift_en   register strobe
//   data_in    register parallel/serial data
//   busy       high in RUN or DONE
//   done       one-cycle completion pulse
module usr_seq #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [3:0]       usr_q,
    output logic [1:0]       sel,
    output logic             shift_en,
    output logic [3:0]       data_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHR_ZERO = 2'b01;
    localparam logic [1:0] OP_SHR_IN   = 2'b10;
    localparam logic [1:0] OP_SHL_IN   = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    // State and command registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            data_q  <= 4'b0000;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Ready is withheld during clr so no command is lost to the reset edge.
    assign cmd_ready = (state_q == S_IDLE) && !clr;

    // Next-state logic: accept, count down, completion pulse.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD) begin
                        rem_d   = CNT_W'(1);
                        state_d = S_RUN;
                    end else if (cmd_count == '0) begin
                        // Zero-length shift: no strobe, report completion at once.
                        state_d = S_DONE;
                    end else begin
                        rem_d   = cmd_count;
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output mapping: hold by reloading usr_q outside RUN, op-specific mode in RUN.
    always_comb begin
        sel      = 2'b00;
        shift_en = 1'b0;
        data_in  = usr_q;
        if (state_q == S_RUN) begin
            shift_en = 1'b1;
            data_in  = data_q;
            case (op_q)
                OP_LOAD:     sel = 2'b11;
                OP_SHR_ZERO: sel = 2'b00;
                OP_SHR_IN:   sel = 2'b01;
                OP_SHL_IN:   sel = 2'b10;
                default:     sel = 2'b00;
            endcase
        end else begin
            sel      = 2'b00;
            shift_en = 1'b0;
            data_in  = usr_q;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: a behavioural 4-bit universal shift register closes the
// loop (usr_q), and an arithmetic reference model predicts register contents
// and handshake/strobe timing for directed and random commands.
module tb_usr_seq;

    logic       clk = 1'b0;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_count;
    logic [3:0] usr_q;
    logic [1:0] sel;
    logic       shift_en;
    logic [3:0] data_in;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] mq;                 // predicted register contents
    logic [1:0] sel_of [4] = '{2'd3, 2'd0, 2'd1, 2'd2};

    always #5 clk = ~clk;

    usr_seq #(.CNT_W(4)) dut (
        .clk(clk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .usr_q(usr_q),
        .sel(sel), .shift_en(shift_en), .data_in(data_in),
        .busy(busy), .done(done)
    );

    // Universal shift register stage: parallel load when not strobed,
    // serial fill uses data_in[0].
    always_ff @(posedge clk) begin
        if (clr) usr_q <= 4'b0000;
        else if (!shift_en) usr_q <= data_in;
        else begin
            case (sel)
                2'b00:   usr_q <= {1'b0, usr_q[3:1]};
                2'b01:   usr_q <= {data_in[0], usr_q[3:1]};
                2'b10:   usr_q <= {usr_q[2:0], data_in[0]};
                default: usr_q <= data_in;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_step(input logic [3:0] q, input logic [1:0] op,
                                            input logic [3:0] d);
        int qi, di, r;
        qi = int'(q);
        di = int'(d);
        case (op)
            2'd0:    r = di;
            2'd1:    r = qi / 2;
            2'd2:    r = qi / 2 + (di % 2) * 8;
            default: r = (qi * 2) % 16 + di % 2;
        endcase
        return r[3:0];
    endfunction

    // Issue one command from IDLE and check every cycle through return to IDLE.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input int cnt);
        int n;
        n = (op == 2'd0) ? 1 : cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = cnt[3:0];
        chk("ready_pre", {7'd0, cmd_ready}, 8'd1);
        tick;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
        cmd_count = 4'($urandom);
        for (int i = 0; i < n; i++) begin
            chk("strobe",   {7'd0, shift_en}, 8'd1);
            chk("sel_run",  {6'd0, sel}, {6'd0, sel_of[op]});
            chk("din_run",  {4'd0, data_in}, {4'd0, d});
            chk("busy_run", {7'd0, busy}, 8'd1);
            chk("done_run", {7'd0, done}, 8'd0);
            chk("rdy_run",  {7'd0, cmd_ready}, 8'd0);
            tick;
            mq = ref_step(mq, op, d);
            chk("usr_q_step", {4'd0, usr_q}, {4'd0, mq});
        end
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("busy_done",  {7'd0, busy}, 8'd1);
        chk("strobe_dn",  {7'd0, shift_en}, 8'd0);
        chk("sel_done",   {6'd0, sel}, 8'd0);
        chk("din_hold",   {4'd0, data_in}, {4'd0, mq});
        chk("rdy_done",   {7'd0, cmd_ready}, 8'd0);
        tick;
        chk("done_off",   {7'd0, done}, 8'd0);
        chk("busy_idle",  {7'd0, busy}, 8'd0);
        chk("rdy_idle",   {7'd0, cmd_ready}, 8'd1);
        chk("usr_q_idle", {4'd0, usr_q}, {4'd0, mq});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0; cmd_count = 4'd0;
        mq = 4'd0;
        #1;
        tick; tick;
        clr = 1'b0;
        #1;
        chk("rst_busy",  {7'd0, busy}, 8'd0);
        chk("rst_done",  {7'd0, done}, 8'd0);
        chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_sel",   {6'd0, sel}, 8'd0);
        chk("rst_sen",   {7'd0, shift_en}, 8'd0);
        chk("rst_din",   {4'd0, data_in}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_q", {4'd0, usr_q}, 8'd0);
        end

        // LOAD 1011, then SHR_ZERO x2 with explicit values.
        run_cmd(2'd0, 4'b1011, 0);
        chk("load_val", {4'd0, usr_q}, 8'b0000_1011);
        run_cmd(2'd1, 4'b0000, 2);
        chk("shr0_val", {4'd0, usr_q}, 8'b0000_0010);

        // From 0000, SHL_IN fill 1 x3 -> 0111.
        run_cmd(2'd0, 4'b0000, 0);
        run_cmd(2'd3, 4'b0001, 3);
        chk("shl_val", {4'd0, usr_q}, 8'b0000_0111);

        // Count 0 with the next command held on cmd_valid through DONE.
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 4'b1111; cmd_count = 4'd0;
        tick;                               // E0
        cmd_op = 2'd0; cmd_data = 4'b1001;  // next command, held
        chk("c0_done",  {7'd0, done}, 8'd1);
        chk("c0_sen",   {7'd0, shift_en}, 8'd0);
        chk("c0_rdy",   {7'd0, cmd_ready}, 8'd0);
        tick;                               // E1
        chk("c0_q",     {4'd0, usr_q}, {4'd0, mq});
        chk("c0_idle",  {7'd0, busy}, 8'd0);
        chk("c0_done2", {7'd0, done}, 8'd0);
        tick;                               // E2: held LOAD accepted
        cmd_valid = 1'b0;
        chk("c0_acc_busy", {7'd0, busy}, 8'd1);
        chk("c0_acc_sel",  {6'd0, sel}, 8'd3);
        chk("c0_acc_sen",  {7'd0, shift_en}, 8'd1);
        tick;
        mq = 4'b1001;
        chk("c0_acc_q", {4'd0, usr_q}, 8'h09);
        chk("c0_acc_dn", {7'd0, done}, 8'd1);
        tick;

        // Maximum count: 15 strobes, no wrap.
        run_cmd(2'd2, 4'b0001, 15);
        chk("max_val", {4'd0, usr_q}, 8'h0F);

        // Reset during the second strobe cycle of a count-5 shift.
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 4'b0001; cmd_count = 4'd5;
        tick;                               // E0
        cmd_valid = 1'b0;
        tick;                               // E1: now in second strobe cycle
        chk("ab_sen", {7'd0, shift_en}, 8'd1);
        clr = 1'b1;
        #1;
        chk("ab_rdy_clr", {7'd0, cmd_ready}, 8'd0);
        tick;
        mq = 4'd0;
        chk("ab_q",    {4'd0, usr_q}, 8'd0);
        chk("ab_busy", {7'd0, busy}, 8'd0);
        chk("ab_done", {7'd0, done}, 8'd0);
        clr = 1'b0;
        #1;
        chk("ab_rdy", {7'd0, cmd_ready}, 8'd1);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("ab_nodone", {7'd0, done}, 8'd0);
            chk("ab_q_hold", {4'd0, usr_q}, 8'd0);
        end
        run_cmd(2'd0, 4'b0110, 0);
        chk("ab_load", {4'd0, usr_q}, 8'h06);

        // Random commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] rop;
            logic [3:0] rd;
            int rc;
            rop = 2'($urandom);
            rd  = 4'($urandom);
            rc  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            run_cmd(rop, rd, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usr_seq.md
# usr_seq

Command sequencer directly upstream of the 4-bit universal shift register stage. It accepts one operation per valid/ready handshake and drives the register's `sel`, `shift_en` and `data_in` inputs for exactly the commanded number of cycles. Between operations it forces the register to hold its contents by feeding the register output back as a parallel load. It signals completion with a one-cycle `done` pulse.

## Interface
- `CNT_W`, default 4: width of the repeat count; maximum count is 2^CNT_W-1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clr` in 1: synchronous, active-high reset. It is shared with the shift-register stage.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the sequencer can accept a command.
- `cmd_op` in 2: operation code.
  - 00 = LOAD
  - 01 = SHR_ZERO (shift toward bit 0, zero fill)
  - 10 = SHR_IN (shift toward bit 0, serial fill)
  - 11 = SHL_IN (shift toward bit 3, serial fill)
- `cmd_data` in 4: load value, or serial-fill source, latched at accept.
- `cmd_count` in CNT_W: number of shift cycles; ignored for LOAD.
- `usr_q` in 4: current output of the shift-register stage, used for hold.
- `sel` out 2: to the shift register.
- `shift_en` out 1: to the shift register.
- `data_in` out 4: to the shift register.
- `busy` out 1: high in RUN or DONE.
- `done` out 1: one-cycle completion pulse.

## Operation
- State machine with states IDLE, RUN and DONE. Registers: `state`, `op_r[1:0]`, `data_r[3:0]`, `rem[CNT_W-1:0]`.
- **IDLE**
  - `cmd_ready` = 1, except when `clr` = 1, in which case it is 0.
  - Accept on `cmd_valid && cmd_ready` at a rising edge. At accept, latch `op_r`/`data_r`.
  - LOAD: `rem` <= 1, go to RUN.
  - Shift op with `cmd_count` = 0: go directly to DONE. No strobe is issued.
  - Shift op otherwise: `rem` <= `cmd_count`, go to RUN.
- **RUN**
  - `shift_en` = 1 every cycle. `rem` decrements each edge.
  - When `rem` = 1 at an edge, go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle, then go to IDLE.
- Output mapping (combinational from state and registers):
  - Hold (IDLE, DONE): `sel`=00, `shift_en`=0, `data_in`=`usr_q`. The register reloads its own value and is therefore unchanged.
  - RUN/LOAD: `sel`=11, `data_in`=`data_r`.
  - RUN/SHR_ZERO: `sel`=00, `data_in`=`data_r` (don't-care to the register).
  - RUN/SHR_IN: `sel`=01, `data_in`=`data_r`.
  - RUN/SHL_IN: `sel`=10, `data_in`=`data_r`.
- `busy` = (`state` != IDLE).
- `cmd_op`, `cmd_data` and `cmd_count` are only sampled at accept. Changes to them while busy have no effect.
- **Reset**
  - `clr` at any edge forces IDLE, `rem` = 0, `op_r` = 00, `data_r` = 0.
  - After the reset edge: `done` = 0, `busy` = 0, hold outputs driven, `cmd_ready` = 1 once `clr` deasserts.
  - A reset mid-RUN aborts the operation. No `done` is issued for an aborted command.

## Timing
- Accept at edge E0. The shift register updates at edges E1..EN, where N = 1 for LOAD and N = `cmd_count` otherwise.
- `done` is high during the cycle between EN and EN+1.
- Earliest next accept is at EN+2, so back-to-back commands have a one-cycle DONE bubble.
- Count 0: `done` is high between E0 and E1. The next accept is at E2. `usr_q` is unchanged.
- Maximum count (15 at `CNT_W`=4): 15 consecutive strobe cycles with no wrap of `rem`.
- `cmd_valid` held high through DONE is not accepted until IDLE is reached.
- `data_in` in hold is a combinational path from `usr_q`. The register must not have a combinational path from `data_in` to `usr_q`.
- Latency from accept to first register update: 1 edge.

## Test plan
- Reset: drive `clr`=1 for 2 cycles, then release.
  - Required: `busy`=0, `done`=0, `cmd_ready`=1, `sel`=00, `shift_en`=0, `data_in`==`usr_q`.
  - `usr_q` stays 0000 for 10 idle cycles.
- LOAD, `cmd_data`=1011: `shift_en`=1, `sel`=11 for 1 cycle. `usr_q`=1011 after E1. `done` pulses once. `usr_q` stays 1011 in IDLE.
- From 1011, SHR_ZERO with count 2:
  - Exactly 2 strobe cycles, `sel`=00.
  - `usr_q` sequence: 0101, then 0010.
  - `done` is high during the cycle after E2.
- From 0000, SHL_IN with `cmd_data`=0001, count 3: 3 strobes with `sel`=10, and `done` is required during the cycle after E3. The bench also checks that `cmd_ready`=0 throughout.
- Shift op with count 0:
  - `done` is high the cycle after accept.
  - No `shift_en`.
  - `usr_q` unchanged.
  - A new command held on `cmd_valid` is accepted at E2.
- Assert `clr` during the second cycle of a count-5 shift: no `done`, `usr_q`=0000, `cmd_ready`=1 the cycle after `clr` deasserts. A subsequent LOAD of 0110 completes normally.
